// File: rtl/pico_ctrl_pkg.sv
// Shared types and defaults for the picoMIPS run-control sequencer.
// Build option PICO_STEP_EN (single-step mode) is consumed by pico_run_ctrl.
package pico_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RUN     = 3'd1,
    WAIT_SW = 3'd2,
    EXEC    = 3'd3,
    PAUSE   = 3'd4,
    HALT    = 3'd5
  } run_state_t;

  localparam int DB_CYCLES_DEF = 16;

  // An instruction retires in RUN unless the decoder asks to halt or wait; EXEC always retires.
  function automatic logic exec_en(input run_state_t st, input logic wreq, input logic hreq);
    logic en;
    case (st)
      RUN:     en = ~wreq & ~hreq;
      EXEC:    en = 1'b1;
      default: en = 1'b0;
    endcase
    return en;
  endfunction

endpackage

// File: rtl/pico_debounce.sv
// Operator switch conditioning: 2-flop synchronizer, stability counter,
// debounced level and a one-cycle press pulse on each accepted 1->0 change.
module pico_debounce
  import pico_ctrl_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic sw8,
  output logic sw_db,
  output logic press_evt
);

  localparam int CW = $clog2(DB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          sync1_r;
  logic          sync2_r;
  logic [CW-1:0] cnt_r;
  logic          sw_db_r;
  logic          sw_db_d_r;
  logic          press_evt_r;

  // Bring the raw switch into the clock domain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= sw8;
      sync2_r <= sync1_r;
    end
  end

  // Accept a new level only after DB_CYCLES consecutive differing samples.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r   <= '0;
      sw_db_r <= 1'b0;
    end else if (sync2_r != sw_db_r) begin
      if (cnt_r == CNT_LAST) begin
        sw_db_r <= sync2_r;
        cnt_r   <= '0;
      end else begin
        cnt_r   <= cnt_r + CW'(1);
      end
    end else begin
      cnt_r <= '0;
    end
  end

  // Press pulse follows the cycle in which the debounced level fell.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sw_db_d_r   <= 1'b0;
      press_evt_r <= 1'b0;
    end else begin
      sw_db_d_r   <= sw_db_r;
      press_evt_r <= sw_db_d_r & ~sw_db_r;
    end
  end

  assign sw_db     = sw_db_r;
  assign press_evt = press_evt_r;

endmodule

// File: rtl/pico_run_ctrl.sv
// Run-control FSM for the picoMIPS core: gates PC/regfile updates, stalls on
// switch-reading instructions, tracks halt. Define PICO_STEP_EN for single-step.
module pico_run_ctrl
  import pico_ctrl_pkg::*;
#(
  parameter int n         = 8,
  parameter int DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         sw8,
  input  logic         wait_req,
  input  logic         halt_req,
  output logic         pc_en,
  output logic         wr_en,
  output logic         disp_sel,
  output logic         press_evt,
  output logic [2:0]   state,
  output logic [n-1:0] icount
);

  run_state_t   state_r;
  run_state_t   next_state_s;
  logic         exec_s;
  logic         sw_db_s;
  logic         press_evt_s;
  logic [n-1:0] icount_r;

  pico_debounce #(.DB_CYCLES(DB_CYCLES)) u_debounce (
    .clk       (clk),
    .reset     (reset),
    .sw8       (sw8),
    .sw_db     (sw_db_s),
    .press_evt (press_evt_s)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state and enable decode; enables are combinational on the decoder requests.
  always_comb begin
    next_state_s = state_r;
    exec_s       = exec_en(state_r, wait_req, halt_req);
    case (state_r)
      IDLE: begin
        if (press_evt_s) next_state_s = RUN;
        else             next_state_s = IDLE;
      end
      RUN: begin
        if (halt_req)      next_state_s = HALT;
        else if (wait_req) next_state_s = WAIT_SW;
        else begin
`ifdef PICO_STEP_EN
          next_state_s = PAUSE;
`else
          next_state_s = RUN;
`endif
        end
      end
      WAIT_SW: begin
        if (press_evt_s) next_state_s = EXEC;
        else             next_state_s = WAIT_SW;
      end
      EXEC: begin
`ifdef PICO_STEP_EN
        next_state_s = PAUSE;
`else
        next_state_s = RUN;
`endif
      end
      PAUSE: begin
        if (press_evt_s) next_state_s = RUN;
        else             next_state_s = PAUSE;
      end
      HALT:    next_state_s = HALT;
      default: next_state_s = IDLE;
    endcase
  end

  // Executed-instruction counter, wrapping naturally at 2^n.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      icount_r <= '0;
    end else if (exec_s) begin
      icount_r <= icount_r + n'(1);
    end else begin
      icount_r <= icount_r;
    end
  end

  assign pc_en     = exec_s;
  assign wr_en     = exec_s;
  assign disp_sel  = sw_db_s;
  assign press_evt = press_evt_s;
  assign state     = state_r;
  assign icount    = icount_r;

endmodule

// File: tb/tb_pico_run_ctrl.sv
// Self-checking bench for pico_run_ctrl: per-cycle comparison against a
// behavioural model plus hand-computed checkpoints (DB_CYCLES=4).
module tb_pico_run_ctrl;

  localparam int DB = 4;
  localparam int N  = 8;
`ifdef PICO_STEP_EN
  localparam bit STEP = 1'b1;
`else
  localparam bit STEP = 1'b0;
`endif

  logic         clk      = 1'b0;
  logic         reset    = 1'b1;
  logic         sw8      = 1'b1;
  logic         wait_req = 1'b0;
  logic         halt_req = 1'b0;
  logic         pc_en;
  logic         wr_en;
  logic         disp_sel;
  logic         press_evt;
  logic [2:0]   state;
  logic [N-1:0] icount;

  int n_checks = 0;
  int n_fail   = 0;

  pico_run_ctrl #(.n(N), .DB_CYCLES(DB)) dut (
    .clk       (clk),
    .reset     (reset),
    .sw8       (sw8),
    .wait_req  (wait_req),
    .halt_req  (halt_req),
    .pc_en     (pc_en),
    .wr_en     (wr_en),
    .disp_sel  (disp_sel),
    .press_evt (press_evt),
    .state     (state),
    .icount    (icount)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: states 0 idle,1 run,2 wait,3 exec,4 pause,5 halt.
  int   m_state;
  int   m_icount;
  logic m_db;
  logic m_press;
  logic m_fall_pend;
  logic hist [0:DB];   // hist[0] = raw switch sampled at previous edge

  function automatic logic m_exec(input int st, input logic w, input logic h);
    return (st == 1 && !w && !h) || st == 3;
  endfunction

  always @(posedge clk or posedge reset) begin
    int   nxt;
    logic stable;
    logic new_db;
    if (reset) begin
      m_state     <= 0;
      m_icount    <= 0;
      m_db        <= 1'b0;
      m_press     <= 1'b0;
      m_fall_pend <= 1'b0;
      for (int i = 0; i <= DB; i++) hist[i] <= 1'b0;
    end else begin
      nxt = m_state;
      if (m_state == 0 && m_press) nxt = 1;
      else if (m_state == 1) nxt = halt_req ? 5 : (wait_req ? 2 : (STEP ? 4 : 1));
      else if (m_state == 2 && m_press) nxt = 3;
      else if (m_state == 3) nxt = STEP ? 4 : 1;
      else if (m_state == 4 && m_press) nxt = 1;
      // the synchronized sample seen now is the raw value from two edges back
      stable = 1'b1;
      for (int i = 1; i <= DB; i++) if (hist[i] == m_db) stable = 1'b0;
      new_db = stable ? ~m_db : m_db;
      m_state     <= nxt;
      m_icount    <= m_exec(m_state, wait_req, halt_req) ? (m_icount + 1) % 256 : m_icount;
      m_db        <= new_db;
      m_press     <= m_fall_pend;
      m_fall_pend <= m_db & ~new_db;
      hist[0]     <= sw8;
      for (int i = 1; i <= DB; i++) hist[i] <= hist[i-1];
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    logic e;
    e = m_exec(m_state, wait_req, halt_req);
    check("state", int'(state), m_state);
    check("pc_en", int'(pc_en), int'(e));
    check("wr_en", int'(wr_en), int'(e));
    check("disp_sel", int'(disp_sel), int'(m_db));
    check("press_evt", int'(press_evt), int'(m_press));
    check("icount", int'(icount), m_icount);
  end

  task automatic cyc(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; sw8 = 1'b1; wait_req = 1'b0; halt_req = 1'b0;
    cyc(3);
    reset = 1'b0;
    cyc(5);
    check("lit_disp_before_rise", int'(disp_sel), 0);
    check("lit_idle_after_reset", int'(state), 0);
    cyc(1);
    check("lit_disp_rise_at_6", int'(disp_sel), 1);
    cyc(4);

    // first press
    sw8 = 1'b0;
    cyc(6);
    check("lit_press_not_yet", int'(press_evt), 0);
    cyc(1);
    check("lit_press_at_7", int'(press_evt), 1);
    cyc(1);
    check("lit_run_after_press", int'(state), 1);
    check("lit_pc_en_run", int'(pc_en), 1);
`ifdef PICO_STEP_EN
    cyc(1);
    check("lit_step_pause1", int'(state), 4);
    check("lit_step_icount1", int'(icount), 1);
    for (int p = 0; p < 2; p++) begin
      sw8 = 1'b1;
      cyc(8);
      sw8 = 1'b0;
      cyc(8);
      check("lit_step_run", int'(state), 1);
      cyc(1);
    end
    check("lit_step_icount3", int'(icount), 3);
    check("lit_step_pause3", int'(state), 4);
`else
    cyc(3);
    check("lit_icount_3", int'(icount), 3);
    sw8 = 1'b1;
    cyc(8);

    // stall on a switch-reading instruction
    wait_req = 1'b1;
    #1;
    check("lit_wait_pc_en", int'(pc_en), 0);
    check("lit_wait_wr_en", int'(wr_en), 0);
    cyc(1);
    check("lit_wait_state", int'(state), 2);

    // short glitch is rejected
    sw8 = 1'b0;
    cyc(3);
    sw8 = 1'b1;
    cyc(10);
    check("lit_glitch_state", int'(state), 2);

    // confirm press -> one EXEC cycle
    sw8 = 1'b0;
    cyc(8);
    check("lit_exec_state", int'(state), 3);
    check("lit_exec_pc_en", int'(pc_en), 1);
    wait_req = 1'b0;
    cyc(1);
    check("lit_back_to_run", int'(state), 1);
    sw8 = 1'b1;
    cyc(8);

    // reset mid-run, then 256-cycle wrap
    reset = 1'b1;
    #1;
    check("lit_rst_state", int'(state), 0);
    check("lit_rst_icount", int'(icount), 0);
    cyc(2);
    reset = 1'b0;
    cyc(8);
    sw8 = 1'b0;
    cyc(8);
    check("lit_wrap_run", int'(state), 1);
    check("lit_wrap_start", int'(icount), 0);
    cyc(255);
    check("lit_wrap_255", int'(icount), 255);
    cyc(1);
    check("lit_wrap_0", int'(icount), 0);

    // halt wins over wait; presses ignored, display still tracks switch
    wait_req = 1'b1;
    halt_req = 1'b1;
    #1;
    check("lit_halt_pc_en", int'(pc_en), 0);
    cyc(1);
    check("lit_halt_state", int'(state), 5);
    sw8 = 1'b1;
    cyc(10);
    check("lit_halt_disp_hi", int'(disp_sel), 1);
    sw8 = 1'b0;
    cyc(10);
    check("lit_halt_after_press", int'(state), 5);
    check("lit_halt_disp_lo", int'(disp_sel), 0);
    sw8 = 1'b1;
    cyc(10);
    check("lit_halt_disp_hi2", int'(disp_sel), 1);

    reset = 1'b1;
    #1;
    check("lit_rst2_state", int'(state), 0);
    check("lit_rst2_pc_en", int'(pc_en), 0);
    check("lit_rst2_wr_en", int'(wr_en), 0);
    check("lit_rst2_icount", int'(icount), 0);
    check("lit_rst2_disp", int'(disp_sel), 0);
    check("lit_rst2_press", int'(press_evt), 0);
`endif
    cyc(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
